// File: rtl/trimmed_filter_param_if.sv
// Stream interface for the alpha-trimmed filter.
// Purpose : groups the sample-side and result-side signals of the filter so
//           the source/writer and the filter connect through one port.
// Signals : in_valid - sample qualifier (source -> filter)
//           P        - unsigned sample, DATA_W bits
//           mode     - result select sampled with P (00 trim, 01 median,
//                      10 full mean, 11 behaves as 00)
//           flush    - window clear request
//           out      - filter result, DATA_W bits (filter -> sink)
//           out_valid- one-cycle result qualifier
// Modports: master = source/sink side, slave = filter side.
interface trimmed_filter_param_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] P;
  logic [1:0]        mode;
  logic              flush;
  logic [DATA_W-1:0] out;
  logic              out_valid;

  modport master (
    output in_valid, P, mode, flush,
    input  out, out_valid
  );

  modport slave (
    input  in_valid, P, mode, flush,
    output out, out_valid
  );
endinterface

// File: rtl/trimmed_filter_param.sv
// Parametrised streaming alpha-trimmed filter.
// Purpose : keeps a sliding window of the last WIN accepted samples, ranks
//           them, and per sample emits the trimmed mean, the median or the
//           full mean (floored). Four-cycle latency, one result per cycle.
// Ports   : clk - rising-edge clock
//           rst - synchronous active-high reset (drops in-flight results)
//           bus - trimmed_filter_param_if.slave (in_valid, P, mode, flush,
//                 out, out_valid)
// Pipeline: p0 window/mode/valid, p1 ranks, p2 selected sum, p3 quotient,
//           then the output register.
module trimmed_filter_param #(
  parameter int DATA_W = 8,
  parameter int WIN    = 5,
  parameter int TRIM   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  trimmed_filter_param_if.slave bus
);

  localparam int RANK_W = $clog2(WIN);
  localparam int SUM_W  = DATA_W + $clog2(WIN);
  localparam int CNT_W  = $clog2(WIN + 1);
  localparam int MID    = (WIN - 1) / 2;

  localparam logic [1:0] MODE_MED  = 2'b01;
  localparam logic [1:0] MODE_FULL = 2'b10;

  localparam logic [SUM_W-1:0] DIV_TRIM = SUM_W'(WIN - 2 * TRIM);
  localparam logic [SUM_W-1:0] DIV_FULL = SUM_W'(WIN);

  if ((WIN % 2) == 0 || WIN < 3 || WIN > 15 || TRIM < 0 || TRIM > (WIN - 1) / 2)
  begin : g_bad_param
    $error("trimmed_filter_param: WIN must be odd in 3..15 and 0 <= TRIM <= (WIN-1)/2");
  end

  // Constant divisors; the median path bypasses the divide. Quotient always
  // fits DATA_W because it never exceeds the largest sample.
  function automatic logic [DATA_W-1:0] floor_div(input logic [SUM_W-1:0] s,
                                                  input logic [1:0]       m);
    logic [SUM_W-1:0] q;
    case (m)
      MODE_MED:  q = s;
      MODE_FULL: q = s / DIV_FULL;
      default:   q = s / DIV_TRIM;
    endcase
    return DATA_W'(q);
  endfunction

  logic              accept;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic              full_d;

  logic [DATA_W-1:0] w_q [WIN];
  logic [1:0]        mode_p0_q;
  logic              vld_p0_q;

  logic [RANK_W-1:0] rank_d    [WIN];
  logic [DATA_W-1:0] win_p1_q  [WIN];
  logic [RANK_W-1:0] rank_p1_q [WIN];
  logic [1:0]        mode_p1_q;
  logic              vld_p1_q;

  logic [SUM_W-1:0]  sum_all, sum_trim, sum_d;
  logic [DATA_W-1:0] med;
  logic [SUM_W-1:0]  sum_p2_q;
  logic [1:0]        mode_p2_q;
  logic              vld_p2_q;

  logic [DATA_W-1:0] q_p3_q;
  logic              vld_p3_q;

  logic [DATA_W-1:0] out_q;
  logic              out_valid_q;

  // A flush on the same edge wins over the sample, which is dropped.
  assign accept = bus.in_valid && !bus.flush;

  always_comb begin
    fill_d = fill_q;
    if (bus.flush) begin
      fill_d = '0;
    end else if (accept && fill_q != CNT_W'(WIN)) begin
      fill_d = fill_q + CNT_W'(1);
    end
  end

  // Full counts the sample being shifted in on this edge.
  assign full_d = (fill_d == CNT_W'(WIN));

  // ---- p0 -> p1: rank every window slot; equal values break by index ----
  always_comb begin
    for (int i = 0; i < WIN; i++) begin
      rank_d[i] = '0;
    end
    for (int i = 0; i < WIN; i++) begin
      for (int j = 0; j < WIN; j++) begin
        if (j != i) begin
          if (w_q[j] < w_q[i] || (w_q[j] == w_q[i] && j < i)) begin
            rank_d[i] = rank_d[i] + RANK_W'(1);
          end
        end
      end
    end
  end

  // ---- p1 -> p2: select by rank and accumulate ----
  always_comb begin
    sum_all  = '0;
    sum_trim = '0;
    med      = '0;
    for (int i = 0; i < WIN; i++) begin
      sum_all = sum_all + SUM_W'(win_p1_q[i]);
      if (int'(rank_p1_q[i]) >= TRIM && int'(rank_p1_q[i]) <= WIN - 1 - TRIM) begin
        sum_trim = sum_trim + SUM_W'(win_p1_q[i]);
      end
      if (int'(rank_p1_q[i]) == MID) begin
        med = win_p1_q[i];
      end
    end
    case (mode_p1_q)
      MODE_MED:  sum_d = SUM_W'(med);
      MODE_FULL: sum_d = sum_all;
      default:   sum_d = sum_trim;
    endcase
  end

  // Control state, window and output register: cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= '0;
      for (int i = 0; i < WIN; i++) begin
        w_q[i] <= '0;
      end
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      vld_p3_q    <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
      // ---- p0: window shift ----
      if (accept) begin
        w_q[0] <= bus.P;
        for (int i = 1; i < WIN; i++) begin
          w_q[i] <= w_q[i-1];
        end
      end
      vld_p0_q <= accept && full_d;
      // ---- p1 / p2 / p3 ----
      vld_p1_q <= vld_p0_q;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
      // ---- output: hold the last result through bubbles ----
      out_valid_q <= vld_p3_q;
      if (vld_p3_q) begin
        out_q <= q_p3_q;
      end
    end
  end

  // Datapath pipeline registers; qualified only by the valids above.
  always_ff @(posedge clk) begin
    // ---- p0 ----
    if (accept) begin
      mode_p0_q <= bus.mode;
    end
    // ---- p1 ----
    win_p1_q  <= w_q;
    rank_p1_q <= rank_d;
    mode_p1_q <= mode_p0_q;
    // ---- p2 ----
    sum_p2_q  <= sum_d;
    mode_p2_q <= mode_p1_q;
    // ---- p3 ----
    q_p3_q    <= floor_div(sum_p2_q, mode_p2_q);
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

endmodule
